// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - execute-stage multiply/divide unit owning HI/LO; optional MDU_MADD_EN adds madd/maddu/msub/msubu
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        md_start,
  output logic        md_busy,
  output logic [31:0] md_rd,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic        busy_n;
  logic [31:0] hi_n;
  logic [31:0] lo_n;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic [31:0] pend_hi_n;
  logic [31:0] pend_lo_n;
  logic        pend_wr;
  logic        pend_wr_n;

  logic        op_mult;
  logic        op_div;
  logic        op_signed;
`ifdef MDU_MADD_EN
  logic        op_acc;
  logic        op_sub;
`endif

  logic [63:0] rs_ext;
  logic [63:0] rt_ext;
  logic [63:0] product;
  logic [63:0] mult_res;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] rs_abs;
  logic [31:0] rt_abs;
  logic [31:0] rt_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Opcode decode: classify the op and its signedness; unknown codes fall through as bubbles
  always_comb begin
    op_mult   = 1'b0;
    op_div    = 1'b0;
    op_signed = 1'b0;
`ifdef MDU_MADD_EN
    op_acc    = 1'b0;
    op_sub    = 1'b0;
`endif
    case (md_op)
      OP_MULT:  begin op_mult = 1'b1; op_signed = 1'b1; end
      OP_MULTU: begin op_mult = 1'b1; end
      OP_DIV:   begin op_div  = 1'b1; op_signed = 1'b1; end
      OP_DIVU:  begin op_div  = 1'b1; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin op_mult = 1'b1; op_signed = 1'b1; op_acc = 1'b1; end
      OP_MADDU: begin op_mult = 1'b1; op_acc = 1'b1; end
      OP_MSUB:  begin op_mult = 1'b1; op_signed = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      OP_MSUBU: begin op_mult = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
      default:  ;
    endcase
  end

  // Accept a mult/div-class op only when nothing is in flight
  assign md_start = (op_mult | op_div) & ~md_busy;

  // mfhi/mflo read port returns the architectural (possibly stale) register
  assign md_rd = (md_op == OP_MFHI) ? hi :
                 (md_op == OP_MFLO) ? lo : 32'h0;

  // Multiplier: one 64x64 unsigned multiply of extended operands serves signed and unsigned forms
  always_comb begin
    rs_ext  = op_signed ? {{32{rs_val[31]}}, rs_val} : {32'h0, rs_val};
    rt_ext  = op_signed ? {{32{rt_val[31]}}, rt_val} : {32'h0, rt_val};
    product = rs_ext * rt_ext;
`ifdef MDU_MADD_EN
    if (op_acc)
      mult_res = op_sub ? ({hi, lo} - product) : ({hi, lo} + product);
    else
      mult_res = product;
`else
    mult_res = product;
`endif
  end

  // Divider: magnitude divide then sign fix-up; 0x80000000/-1 naturally wraps to 0x80000000 rem 0
  always_comb begin
    rs_neg  = op_signed & rs_val[31];
    rt_neg  = op_signed & rt_val[31];
    rs_abs  = rs_neg ? (32'h0 - rs_val) : rs_val;
    rt_abs  = rt_neg ? (32'h0 - rt_val) : rt_val;
    rt_safe = (rt_abs == 32'h0) ? 32'h1 : rt_abs;
    q_mag   = rs_abs / rt_safe;
    r_mag   = rs_abs % rt_safe;
    quot    = (rs_neg ^ rt_neg) ? (32'h0 - q_mag) : q_mag;
    rem     = rs_neg ? (32'h0 - r_mag) : r_mag;
  end

  // Control state is a view of the down-counter: zero means idle
  always_comb begin
    state = md_busy ? RUN : IDLE;
  end

  // Next-state: accept/launch in IDLE, count down and retire in RUN
  always_comb begin
    cnt_n     = cnt;
    hi_n      = hi;
    lo_n      = lo;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_wr_n = pend_wr;
    case (state)
      IDLE: begin
        if (md_start) begin
          if (op_div) begin
            cnt_n     = DIV_CNT;
            pend_hi_n = rem;
            pend_lo_n = quot;
            // divide by zero still occupies the unit but leaves HI/LO alone
            pend_wr_n = (rt_val != 32'h0);
          end else begin
            cnt_n     = MULT_CNT;
            pend_hi_n = mult_res[63:32];
            pend_lo_n = mult_res[31:0];
            pend_wr_n = 1'b1;
          end
        end else if (md_op == OP_MTHI) begin
          hi_n = rs_val;
        end else if (md_op == OP_MTLO) begin
          lo_n = rs_val;
        end
      end
      RUN: begin
        if (cnt == 4'd1) begin
          cnt_n = 4'd0;
          if (pend_wr) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: ;
    endcase
    busy_n = (cnt_n != 4'd0);
  end

  // State register: reset discards any in-flight result
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 4'd0;
      md_busy <= 1'b0;
      hi      <= 32'h0;
      lo      <= 32'h0;
      pend_hi <= 32'h0;
      pend_lo <= 32'h0;
      pend_wr <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      md_busy <= busy_n;
      hi      <= hi_n;
      lo      <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_wr <= pend_wr_n;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - scoreboard bench for e_mdu against a cycle-level arithmetic reference model
module tb_e_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] rs_val = 32'h0;
  logic [31:0] rt_val = 32'h0;
  logic        md_start;
  logic        md_busy;
  logic [31:0] md_rd;
  logic [31:0] hi;
  logic [31:0] lo;

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_start (md_start),
    .md_busy  (md_busy),
    .md_rd    (md_rd),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        busy;
    logic [31:0] rd;
    logic [31:0] hi;
    logic [31:0] lo;
  } cyc_exp_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } comp_exp_t;

  cyc_exp_t  cyc_q[$];
  comp_exp_t comp_q[$];

  int checks = 0;
  int failures = 0;
  bit armed = 0;
  int cyc = 0;

  // reference model state
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  bit          m_pending = 0;
  bit          m_apply = 0;
  int          m_done = 0;
  int          m_acc_c = 0;
  logic [31:0] m_rhi = 32'h0;
  logic [31:0] m_rlo = 32'h0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // 0 none, 1 multiply class, 2 divide class
  function automatic int op_class(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: return 1;
      4'd3, 4'd4: return 2;
`ifdef MDU_MADD_EN
      4'd9, 4'd10, 4'd11, 4'd12: return 1;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rst);
    cyc_exp_t e;
    comp_exp_t ce;
    int cls;
    bit busy_now;
    longint sa, sb;
    logic [63:0] p, acc, res;
    int ia, ib;
    @(posedge clk);
    #1;
    md_op = op;
    rs_val = a;
    rt_val = b;
    reset = rst;
    cyc++;
    armed = 1;
    if (m_pending && cyc == m_done) begin
      if (m_apply) begin
        m_hi = m_rhi;
        m_lo = m_rlo;
      end
      m_pending = 0;
    end
    busy_now = m_pending;
    cls = op_class(op);
    e.start = (cls != 0) && !busy_now;
    e.busy = busy_now;
    e.rd = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'h0;
    e.hi = m_hi;
    e.lo = m_lo;
    cyc_q.push_back(e);
    if (rst) begin
      if (m_pending) begin
        ce.hi = 32'h0;
        ce.lo = 32'h0;
        ce.len = cyc - m_acc_c;
        comp_q[comp_q.size()-1] = ce;
      end
      m_pending = 0;
      m_hi = 32'h0;
      m_lo = 32'h0;
    end else if (e.start) begin
      m_pending = 1;
      m_acc_c = cyc;
      m_apply = 1;
      if (cls == 1) begin
        if (op == 4'd1 || op == 4'd9 || op == 4'd11) begin
          sa = $signed(a);
          sb = $signed(b);
          p = 64'(sa * sb);
        end else begin
          p = {32'h0, a} * {32'h0, b};
        end
        acc = {m_hi, m_lo};
        if (op == 4'd9 || op == 4'd10) res = acc + p;
        else if (op == 4'd11 || op == 4'd12) res = acc - p;
        else res = p;
        m_rhi = res[63:32];
        m_rlo = res[31:0];
        m_done = cyc + MULT_N + 1;
      end else begin
        m_done = cyc + DIV_N + 1;
        if (b == 32'h0) begin
          m_apply = 0;
          m_rhi = m_hi;
          m_rlo = m_lo;
        end else if (op == 4'd3) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_rlo = 32'h8000_0000;
            m_rhi = 32'h0;
          end else begin
            ia = $signed(a);
            ib = $signed(b);
            m_rlo = 32'(ia / ib);
            m_rhi = 32'(ia % ib);
          end
        end else begin
          m_rlo = a / b;
          m_rhi = a % b;
        end
      end
      ce.hi = m_rhi;
      ce.lo = m_rlo;
      ce.len = m_done - cyc - 1;
      comp_q.push_back(ce);
    end else if (!busy_now && op == 4'd7) begin
      m_hi = a;
    end else if (!busy_now && op == 4'd8) begin
      m_lo = a;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, $urandom, $urandom, 1'b0);
  endtask

  function automatic logic [31:0] rand_operand();
    int s;
    s = $urandom_range(0, 9);
    case (s)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Per-cycle monitor: every recorded cycle's outputs against the model's expectation
  always @(negedge clk) begin
    cyc_exp_t e;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      check32("md_start", {31'h0, md_start}, {31'h0, e.start});
      check32("md_busy", {31'h0, md_busy}, {31'h0, e.busy});
      check32("md_rd", md_rd, e.rd);
      check32("hi", hi, e.hi);
      check32("lo", lo, e.lo);
    end
  end

  // Completion monitor: on each busy fall, check the busy run length and retired HI/LO
  int run_len = 0;
  always @(negedge clk) begin
    comp_exp_t ce;
    if (armed) begin
      if (md_busy === 1'b1) begin
        run_len <= run_len + 1;
      end else if (run_len > 0) begin
        if (comp_q.size() == 0) begin
          check32("completion_unexpected", 32'(run_len), 32'h0);
        end else begin
          ce = comp_q.pop_front();
          check32("busy_len", 32'(run_len), 32'(ce.len));
          check32("done_hi", hi, ce.hi);
          check32("done_lo", lo, ce.lo);
        end
        run_len <= 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1);
  end

  initial begin
    int r;
    logic [3:0] op;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // T1 signed multiply
    step(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(7);
    // T2 divu then signed div with negative dividend
    step(4'd4, 32'd100, 32'd7, 1'b0);
    idle(11);
    step(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(11);
    // T3 mthi then divide by zero
    step(4'd7, 32'h0000_1234, 32'h0, 1'b0);
    step(4'd3, 32'd5, 32'd0, 1'b0);
    idle(11);
    step(4'd5, 32'h0, 32'h0, 1'b0);
    step(4'd6, 32'h0, 32'h0, 1'b0);
    // T4 multiply, second op dropped while busy, mthi ignored while busy
    step(4'd1, 32'd2, 32'd3, 1'b0);
    step(4'd2, 32'd5, 32'd5, 1'b0);
    step(4'd7, 32'hDEAD_BEEF, 32'h0, 1'b0);
    step(4'd5, 32'h0, 32'h0, 1'b0);
    idle(5);
    // signed divide overflow
    step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(11);
    // T5 reset during busy cycle 4
    step(4'd3, 32'd1000, 32'd3, 1'b0);
    idle(3);
    step(4'd0, 32'h0, 32'h0, 1'b1);
    idle(12);
`ifdef MDU_MADD_EN
    // T6 unsigned multiply-accumulate carry into HI
    step(4'd7, 32'h0, 32'h0, 1'b0);
    step(4'd8, 32'hFFFF_FFFF, 32'h0, 1'b0);
    step(4'd10, 32'd1, 32'd1, 1'b0);
    idle(6);
    step(4'd5, 32'h0, 32'h0, 1'b0);
`endif

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 25) op = 4'($urandom_range(1, 2));
      else if (r < 32) op = 4'($urandom_range(9, 12));
      else if (r < 45) op = 4'($urandom_range(3, 4));
      else if (r < 58) op = 4'($urandom_range(5, 6));
      else if (r < 70) op = 4'($urandom_range(7, 8));
      else if (r < 75) op = 4'($urandom_range(13, 15));
      else op = 4'd0;
      step(op, rand_operand(), rand_operand(), ($urandom_range(0, 199) == 0));
    end
    idle(20);
    @(negedge clk);
    #1;
    check32("comp_q_drained", 32'(comp_q.size()), 32'h0);
    check32("cyc_q_drained", 32'(cyc_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
